// File: rtl/incr_arbiter_pkg.sv
// rtl/incr_arbiter_pkg.sv - shared types and helpers for the incrementor arbiter
package incr_arb_pkg;

   localparam int INCR_W  = 16;
   localparam int MAX_IDW = 3;

   typedef struct packed {
      logic [INCR_W-1:0]  data;
      logic               cy;
      logic [MAX_IDW-1:0] id;
   } incr_rsp_t;

   function automatic int rr_next(input int idx, input int nreq);
      return (idx + 1 >= nreq) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/incr_arbiter_if.sv
// rtl/incr_arbiter_if.sv - request/response bundle between clients and the incrementor arbiter
interface incr_arbiter_if
   import incr_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*INCR_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [INCR_W-1:0]      rsp_data;
   logic                   rsp_cy;
   logic [IDW-1:0]         rsp_id;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_cy, rsp_id
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_cy, rsp_id
   );
endinterface

// File: rtl/incr16.sv
// rtl/incr16.sv - 16-bit +1 incrementor with carry out
module incr16 (
   input  logic [15:0] a,
   output logic [15:0] y,
   output logic        cy
);
   // all_ones[i] is the AND of a[i-1:0]: bit i toggles exactly when every lower bit is set
   logic [16:0] all_ones;

   always_comb begin
      all_ones[0] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         all_ones[i+1] = all_ones[i] & a[i];
         y[i]          = a[i] ^ all_ones[i];
      end
      cy = all_ones[16];
   end
endmodule

// File: rtl/incr_arbiter_rr_pick.sv
// rtl/incr_arbiter_rr_pick.sv - combinational round-robin picker, search starts at ptr and wraps
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            any
);
   logic [IDW-1:0] sel;

   // Walk from farthest to nearest so the candidate closest to ptr wins last
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      sel     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sel = IDW'((int'(ptr) + k) % NREQ);
         if (en && req[sel]) begin
            gnt      = '0;
            gnt[sel] = 1'b1;
            gnt_idx  = sel;
            any      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/incr_arbiter.sv
// rtl/incr_arbiter.sv - round-robin sharing of one incr16 among NREQ clients, one registered result slot
module incr_arbiter
   import incr_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   incr_arbiter_if.slave   bus,
   output logic [CNTW-1:0] op_count
);
   typedef enum logic {EMPTY, FULL} slot_e;

   slot_e             state;
   incr_rsp_t         rsp;
   logic [IDW-1:0]    ptr;
   logic              slot_free;
   logic              any;
   logic [NREQ-1:0]   gnt;
   logic [IDW-1:0]    gnt_idx;
   logic [INCR_W-1:0] operand;
   logic [INCR_W-1:0] sum;
   logic              cy;
   logic              unused_id_bits;

   assign slot_free = (state == EMPTY) || bus.rsp_ready;

   // Gating with rst_n keeps grants off for the whole time reset is held
   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req     (bus.req_valid),
      .ptr     (ptr),
      .en      (slot_free && rst_n),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   assign bus.req_ready = gnt;

   always_comb begin
      operand = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) operand = bus.req_data[i*INCR_W +: INCR_W];
   end

   incr16 u_incr (
      .a  (operand),
      .y  (sum),
      .cy (cy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         rsp      <= '0;
         ptr      <= '0;
         op_count <= '0;
      end else if (any) begin
         state    <= FULL;
         rsp.data <= sum;
         rsp.cy   <= cy;
         rsp.id   <= MAX_IDW'(gnt_idx);
         ptr      <= IDW'(rr_next(int'(gnt_idx), NREQ));
         op_count <= op_count + 1'b1;
      end else if (bus.rsp_ready) begin
         state <= EMPTY;
      end
   end

   assign bus.rsp_valid = (state == FULL);
   assign bus.rsp_data  = rsp.data;
   assign bus.rsp_cy    = rsp.cy;
   assign bus.rsp_id    = rsp.id[IDW-1:0];
   assign unused_id_bits = ^rsp.id;
endmodule

// File: tb/tb_incr_arbiter.sv
// tb/tb_incr_arbiter.sv - directed bench with expected-response queue and handshake monitor
module tb_incr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] op_count;
   int          vectors = 0;
   int          miscompares = 0;
   int          hist [4];

   typedef struct {
      logic [15:0] d;
      logic        cy;
      int          id;
   } exp_t;
   exp_t sb [$];

   incr_arbiter_if #(.NREQ(4)) bus ();

   incr_arbiter #(.NREQ(4), .CNTW(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic cy, input int id);
      exp_t e;
      e.d = d; e.cy = cy; e.id = id;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: got id %0d data %0h, expected nothing", bus.rsp_id, bus.rsp_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_data", 32'(bus.rsp_data), 32'(e.d));
            check("rsp_cy",   32'(bus.rsp_cy),   32'(e.cy));
            check("rsp_id",   32'(bus.rsp_id),   32'(e.id));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] res [4];
      res[0] = 16'h0011; res[1] = 16'h0022; res[2] = 16'h0033; res[3] = 16'h0044;
      rst_n         = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_data  = {16'h0043, 16'h0032, 16'h0021, 16'h0010};
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_op_count",  op_count,           32'h0);

      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      #1;
      check("first_grant", 32'(bus.req_ready), 32'h1);

      foreach (hist[j]) hist[j] = 0;
      for (int k = 0; k < 6; k++) begin
         check("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
         if (k < 4)
            for (int j = 0; j < 4; j++) hist[j] += int'(bus.req_ready[j]);
         push(res[k % 4], 1'b0, k % 4);
         tick();
      end
      for (int j = 0; j < 4; j++) check("rr_one_in_four", 32'(hist[j]), 32'd1);
      check("rr_op_count", op_count, 32'd6);
      bus.req_valid = 4'b0000;
      tick();
      check("drain_empty", 32'(bus.rsp_valid), 32'h0);

      bus.req_data[47:32] = 16'h00FF;
      bus.req_valid = 4'b0100;
      #1;
      check("single_grant", 32'(bus.req_ready), 32'h4);
      push(16'h0100, 1'b0, 2);
      tick();
      bus.req_valid = 4'b0000;
      check("single_valid", 32'(bus.rsp_valid), 32'h1);
      check("single_count", op_count, 32'd7);
      tick();

      bus.req_data[31:16] = 16'hFFFF;
      bus.req_valid = 4'b0010;
      #1;
      check("wrap_grant", 32'(bus.req_ready), 32'h2);
      push(16'h0000, 1'b1, 1);
      tick();
      bus.req_valid = 4'b0000;
      check("wrap_cy", 32'(bus.rsp_cy), 32'h1);
      check("wrap_count", op_count, 32'd8);
      tick();

      bus.req_data[15:0] = 16'h1234;
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b0;
      #1;
      check("bp_first_grant", 32'(bus.req_ready), 32'h1);
      push(16'h1235, 1'b0, 0);
      tick();
      bus.req_valid = 4'b1000;
      bus.req_data[63:48] = 16'hABCD;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_no_grant",  32'(bus.req_ready), 32'h0);
         check("bp_valid",     32'(bus.rsp_valid), 32'h1);
         check("bp_data_hold", 32'(bus.rsp_data),  32'h1235);
         check("bp_id_hold",   32'(bus.rsp_id),    32'h0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("drain_fill_grant", 32'(bus.req_ready), 32'h8);
      push(16'hABCE, 1'b0, 3);
      tick();
      bus.req_valid = 4'b0000;
      check("drain_fill_id", 32'(bus.rsp_id), 32'h3);
      check("drain_fill_count", op_count, 32'd10);
      tick();

      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001;
      tick();
      bus.req_valid = 4'b0000;
      check("pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
      check("pre_rst_data",  32'(bus.rsp_data),  32'h1235);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.rsp_valid), 32'h0);
      check("async_rst_data",  32'(bus.rsp_data),  32'h0);
      check("async_rst_count", op_count,           32'h0);
      bus.req_valid = 4'b1111;
      #1;
      check("in_rst_ready", 32'(bus.req_ready), 32'h0);
      rst_n = 1'b1;
      #1;
      check("post_rst_grant", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 4'b0000;
      tick();
      tick();
      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/incr_arbiter.md
Name: incr_arbiter

Overview:
- Shares one Incr16 fast incrementor among NREQ requesters.
- Each cycle at most one request is granted, chosen round-robin. The incremented value and carry are registered into a single output slot with a valid/ready handshake.
- Sits between client blocks that need +1 arithmetic (counters, pointers) and the single Incr16 instance, so the carry chain is not replicated per client.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID tag.
- CNTW, 32, width of the granted-operation statistics counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_data  input  NREQ*16  packed operands; requester i occupies bits [16*i+15:16*i].
- req_ready  output  NREQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i].
- rsp_valid  output  1  output slot holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  16  operand+1, modulo 2^16.
- rsp_cy  output  1  carry out of Incr16; 1 only when operand was 16'hFFFF.
- rsp_id  output  IDW  index of the requester that produced the result.
- op_count  output  CNTW  total accepted requests since reset; wraps modulo 2^CNTW.

Behaviour:
- Reset (rst_n low, asynchronous), effective immediately:
  - rsp_valid=0, rsp_data=0, rsp_cy=0, rsp_id=0, op_count=0.
  - RR pointer=0, so requester 0 has highest priority.
  - An in-flight result is discarded.
  - req_ready=0 while rst_n is low.
- Slot-free condition: slot_free = !rsp_valid || rsp_ready.
- Grant:
  - req_ready is combinational.
  - If slot_free, exactly one bit is set: the first asserted req_valid searching from the RR pointer upward, wrapping NREQ-1 -> 0.
  - Otherwise req_ready=0.
  - No valid requests -> req_ready=0.
- Datapath and latency:
  - The granted req_data slice feeds Incr16 combinationally.
  - On an accepted grant, rsp_data/rsp_cy/rsp_id are loaded and rsp_valid=1 at the next edge.
  - Latency is 1 cycle.
  - Throughput is 1 result/cycle while rsp_ready stays high.
- Output slot states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY + grant -> FULL.
  - FULL + rsp_ready + grant -> FULL with new payload (simultaneous drain and fill).
  - FULL + rsp_ready + no grant -> EMPTY.
  - FULL + !rsp_ready -> FULL with payload held stable; no grant.
- RR pointer update:
  - On each accepted grant to requester g, the pointer becomes (g+1) mod NREQ.
  - With no grant the pointer is unchanged.
  - Starvation bound: NREQ-1 foreign grants before a continuously valid requester is served.
- Requester rules: a requester must hold req_valid and req_data stable until accepted. The arbiter does not latch unaccepted requests.
- op_count increments by 1 per accepted grant and wraps from all-ones to 0.
- rsp_data wrap: operand 16'hFFFF gives rsp_data=0, rsp_cy=1.

Decomposition:
- Package incr_arb_pkg:
  - constant INCR_W=16.
  - typedef incr_rsp_t struct {data[15:0], cy, id}.
  - helper function rr_next(idx, nreq).
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, grant index, any.
- Incr16 is instantiated directly as the shared datapath.

Test Plan:
- Reset values: hold rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, op_count=0. Release reset -> first grant goes to requester 0.
- Single requester: req 2 sends 16'h00FF, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=16'h0100, rsp_cy=0, rsp_id=2, op_count=1.
- Wrap/carry: req 1 sends 16'hFFFF -> rsp_data=16'h0000, rsp_cy=1, rsp_id=1.
- Round-robin fairness: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1. Each req_ready is high exactly 1 cycle in 4.
- Back-pressure: slot FULL and rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_* stable. Raising rsp_ready with req 3 valid -> drain and fill in the same cycle, new rsp_id=3.
- Reset mid-operation: rsp_valid=1 holding 16'h1235, assert rst_n=0 asynchronously -> rsp_valid drops without a clock edge, RR pointer back to 0, op_count=0.
